// File: rtl/mem_access_stage.sv
// Memory-access stage: sits after execute. Performs loads and stores over a
// req/ack data-memory port and registers the write-back result for WB.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16  // BUSY cycles without ack before abort; 0 = never
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data2_i,
  input  logic [4:0]  write_addr_reg_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_we_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        lo_q, lo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_we_q, wb_we_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, mem_op, writes, legal, accept, expire;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_shifted, ld_data;

  assign opcode  = instruction_i[6:0];
  assign funct3  = instruction_i[14:12];
  assign is_load  = (opcode == OpLoad);
  assign is_store = (opcode == OpStore);
  assign mem_op   = is_load | is_store;

  // Decode of register-writing non-memory ops.
  always_comb begin
    writes = 1'b0;
    unique case (opcode)
      OpReg, OpImm, OpLui, OpAuipc, OpJal, OpJalr: writes = 1'b1;
      default: writes = 1'b0;
    endcase
  end

  // Width legality and natural alignment of the requested access.
  always_comb begin
    legal = 1'b0;
    unique case (funct3)
      3'b000:  legal = mem_op;
      3'b001:  legal = mem_op & ~alu_result_i[0];
      3'b010:  legal = mem_op & (alu_result_i[1:0] == 2'b00);
      3'b100:  legal = is_load;
      3'b101:  legal = is_load & ~alu_result_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Lane replication and byte enables for the access (also used for loads).
  always_comb begin
    st_wdata = read_data2_i;
    st_be    = 4'b1111;
    unique case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{read_data2_i[7:0]}};
        st_be    = 4'b0001 << alu_result_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{read_data2_i[15:0]}};
        st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = read_data2_i;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Extract the addressed byte/half from the returned word and extend it.
  always_comb begin
    ld_shifted = dmem_rdata_i >> {lo_q, 3'b000};
    ld_data    = dmem_rdata_i;
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'b0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'b0, ld_shifted[15:0]};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  assign accept = (state_q == StIdle) & valid_i & mem_op & legal;
  assign expire = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Upstream hold: while accepting, and in BUSY until ack or timeout release.
  assign stall_o = (state_q == StIdle) ? accept : (~dmem_ack_i & ~expire);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = 1'b0;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (mem_op) begin
            if (legal) begin
              state_d = StBusy;
              req_d   = 1'b1;
              we_d    = is_store;
              addr_d  = {alu_result_i[31:2], 2'b00};
              wdata_d = st_wdata;
              be_d    = st_be;
              f3_d    = funct3;
              rd_d    = write_addr_reg_i;
              lo_d    = alu_result_i[1:0];
              cnt_d   = '0;
            end else begin
              mis_d = 1'b1;
            end
          end else begin
            wb_data_d = alu_result_i;
            wb_rd_d   = write_addr_reg_i;
            wb_we_d   = writes & (write_addr_reg_i != 5'd0);
          end
        end
      end
      StBusy: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (dmem_ack_i) begin
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          if (!we_q) begin
            wb_data_d = ld_data;
            wb_rd_d   = rd_q;
            wb_we_d   = (rd_q != 5'd0);
          end
        end else if (expire) begin
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          berr_d  = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign wb_data_o    = wb_data_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_we_o      = wb_we_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table plus reset-during-BUSY sequence.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [31:0] instruction_i, alu_result_i, read_data2_i;
  logic [4:0]  write_addr_reg_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o, misaligned_o, bus_err_o;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .valid_i          (valid_i),
    .instruction_i    (instruction_i),
    .alu_result_i     (alu_result_i),
    .read_data2_i     (read_data2_i),
    .write_addr_reg_i (write_addr_reg_i),
    .stall_o          (stall_o),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_rdata_i     (dmem_rdata_i),
    .dmem_ack_i       (dmem_ack_i),
    .wb_data_o        (wb_data_o),
    .wb_rd_o          (wb_rd_o),
    .wb_we_o          (wb_we_o),
    .misaligned_o     (misaligned_o),
    .bus_err_o        (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          ack_cyc;   // BUSY cycle carrying ack; 0 = never
    logic        mem;       // a legal access expected to reach the bus
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] wbd;
    logic        mis;
    logic        berr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
    logic        berr;
  } res_t;

  vec_t vecs[$];
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] rs2,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input int ack_cyc, input logic mem, input logic [3:0] be,
                              input logic [31:0] wdata, input logic we,
                              input logic [31:0] wbd, input logic mis, input logic berr);
    vec_t v;
    v.op = op; v.f3 = f3; v.alu = alu; v.rs2 = rs2; v.rdata = rdata; v.rd = rd;
    v.ack_cyc = ack_cyc; v.mem = mem; v.be = be; v.wdata = wdata; v.we = we;
    v.wbd = wbd; v.mis = mis; v.berr = berr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    res_t  r, e;
    bit    done;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk_i);
    valid_i          = 1'b1;
    instruction_i    = {17'b0, v.f3, 5'b0, v.op};
    alu_result_i     = v.alu;
    read_data2_i     = v.rs2;
    write_addr_reg_i = v.rd;
    dmem_rdata_i     = 32'h0;
    r.we = v.we; r.data = v.wbd; r.rd = v.rd; r.mis = v.mis; r.berr = v.berr;
    exp_q.push_back(r);
    #1;
    check({tag, " stall at issue"}, {31'b0, stall_o}, {31'b0, v.mem});
    @(posedge clk_i);
    if (v.mem) begin
      done = 1'b0;
      for (int c = 1; c <= int'(TO) && !done; c++) begin
        @(negedge clk_i);
        if (c == v.ack_cyc) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = v.rdata;
        end
        #1;
        check({tag, " req"}, {31'b0, dmem_req_o}, 32'd1);
        check({tag, " addr"}, dmem_addr_o, {v.alu[31:2], 2'b00});
        check({tag, " stall busy"}, {31'b0, stall_o},
              {31'b0, (c != v.ack_cyc) && (c != int'(TO))});
        if (v.op == 7'b0100011) begin
          check({tag, " we"}, {31'b0, dmem_we_o}, 32'd1);
          check({tag, " be"}, {28'b0, dmem_be_o}, {28'b0, v.be});
          check({tag, " wdata"}, dmem_wdata_o, v.wdata);
        end
        done = (c == v.ack_cyc) || (c == int'(TO));
        @(posedge clk_i);
      end
    end else begin
      check({tag, " no req"}, {31'b0, dmem_req_o}, 32'd0);
    end
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    valid_i    = 1'b0;
    #1;
    e = exp_q.pop_front();
    check({tag, " wb_we"}, {31'b0, wb_we_o}, {31'b0, e.we});
    if (e.we) begin
      check({tag, " wb_data"}, wb_data_o, e.data);
      check({tag, " wb_rd"}, {27'b0, wb_rd_o}, {27'b0, e.rd});
    end
    check({tag, " misaligned"}, {31'b0, misaligned_o}, {31'b0, e.mis});
    check({tag, " bus_err"}, {31'b0, bus_err_o}, {31'b0, e.berr});
    check({tag, " req after"}, {31'b0, dmem_req_o}, 32'd0);
    @(negedge clk_i);
    check({tag, " pulses drop"}, {29'b0, wb_we_o, misaligned_o, bus_err_o}, 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; instruction_i = '0; alu_result_i = '0;
    read_data2_i = '0; write_addr_reg_i = '0; dmem_rdata_i = '0; dmem_ack_i = 1'b0;

    //        op         f3      alu           rs2           rdata         rd  ack mem be       wdata         we  wbd           mis  berr
    vecs.push_back(mk(7'b0110011, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0, 0, 4'h0, 32'h0, 1, 32'h0000_1234, 0, 0));
    vecs.push_back(mk(7'b0110011, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(7'b0010011, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd31, 0, 0, 4'h0, 32'h0, 1, 32'hCAFE_F00D, 0, 0));
    vecs.push_back(mk(7'b1100011, 3'b000, 32'h0000_0040, 32'h0, 32'h0, 5'd7, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(7'b0110111, 3'b000, 32'hABCD_E000, 32'h0, 32'h0, 5'd1, 0, 0, 4'h0, 32'h0, 1, 32'hABCD_E000, 0, 0));
    vecs.push_back(mk(7'b0000011, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0011, 5'd3, 3, 1, 4'h8, 32'h0, 1, 32'hFFFF_FF80, 0, 0));
    vecs.push_back(mk(7'b0000011, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0011, 5'd3, 3, 1, 4'h8, 32'h0, 1, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(7'b0100011, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 5'd0, 1, 1, 4'hC, 32'hBEEF_BEEF, 0, 32'h0, 0, 0));
    vecs.push_back(mk(7'b0000011, 3'b010, 32'h0000_0301, 32'h0, 32'h0, 5'd4, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(7'b0000011, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 5'd4, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(7'b0000011, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 5'd4, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(7'b0100011, 3'b000, 32'h0000_0401, 32'h1234_5678, 32'h0, 5'd0, 2, 1, 4'h2, 32'h7878_7878, 0, 32'h0, 0, 0));
    vecs.push_back(mk(7'b0100011, 3'b010, 32'h0000_0500, 32'hA5A5_5A5A, 32'h0, 5'd0, 1, 1, 4'hF, 32'hA5A5_5A5A, 0, 32'h0, 0, 0));
    vecs.push_back(mk(7'b0000011, 3'b001, 32'h0000_0602, 32'h0, 32'h8001_7FFF, 5'd10, 1, 1, 4'hC, 32'h0, 1, 32'hFFFF_8001, 0, 0));
    vecs.push_back(mk(7'b0000011, 3'b101, 32'h0000_0600, 32'h0, 32'h8001_7FFF, 5'd11, 2, 1, 4'h3, 32'h0, 1, 32'h0000_7FFF, 0, 0));
    vecs.push_back(mk(7'b0000011, 3'b010, 32'h0000_0704, 32'h0, 32'h1357_9BDF, 5'd0, 1, 1, 4'hF, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(7'b0000011, 3'b010, 32'h0000_0800, 32'h0, 32'h0, 5'd8, 0, 1, 4'hF, 32'h0, 0, 32'h0, 0, 1));
    vecs.push_back(mk(7'b0000011, 3'b010, 32'h0000_0804, 32'h0, 32'h1122_3344, 5'd9, 4, 1, 4'hF, 32'h0, 1, 32'h1122_3344, 0, 0));
    vecs.push_back(mk(7'b0100011, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 5'd0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(7'b0000011, 3'b000, 32'h0000_0002, 32'h0, 32'h00AB_0000, 5'd12, 1, 1, 4'h4, 32'h0, 1, 32'hFFFF_FFAB, 0, 0));

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    check("reset stall", {31'b0, stall_o}, 32'd0);
    check("reset req/we", {30'b0, dmem_req_o, dmem_we_o}, 32'd0);
    check("reset be", {28'b0, dmem_be_o}, 32'd0);
    check("reset wb_data", wb_data_o, 32'd0);
    check("reset wb flags", {24'b0, wb_rd_o, wb_we_o, misaligned_o, bus_err_o}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while BUSY; a late ack afterwards must not write back.
    @(negedge clk_i);
    valid_i          = 1'b1;
    instruction_i    = {17'b0, 3'b010, 5'b0, 7'b0000011};
    alu_result_i     = 32'h0000_0900;
    write_addr_reg_i = 5'd6;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy req before", {31'b0, dmem_req_o}, 32'd1);
    reset_i = 1'b1;
    valid_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("rst_busy req dropped", {31'b0, dmem_req_o}, 32'd0);
    check("rst_busy stall", {31'b0, stall_o}, 32'd0);
    check("rst_busy addr", dmem_addr_o, 32'd0);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    check("late ack wb_we", {31'b0, wb_we_o}, 32'd0);
    check("late ack wb_data", wb_data_o, 32'd0);
    check("late ack req", {31'b0, dmem_req_o}, 32'd0);
    check("scoreboard empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
